// File: rtl/state_sequencer.sv
// Timed sequencer emitting the 4-bit state code stream (0000 idle, 0001..1001 for b..j) for the downstream decoder.
// Optional macro SEQ_LOOP_EN: j wraps back to b instead of returning to idle.
module state_sequencer #(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned DWELL_SHORT = 2,
  parameter int unsigned DWELL_LONG  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       skip,
  output logic [3:0] stateout,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = 8;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] SHORT_MAX = DW'(DWELL_SHORT - 1);
  localparam logic [DW-1:0] LONG_MAX  = DW'(DWELL_LONG - 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_B    = 4'd1,
    ST_C    = 4'd2,
    ST_D    = 4'd3,
    ST_E    = 4'd4,
    ST_F    = 4'd5,
    ST_G    = 4'd6,
    ST_H    = 4'd7,
    ST_I    = 4'd8,
    ST_J    = 4'd9
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick_c;
  logic          advance_c;
  logic [DW-1:0] dwell_max_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: skip beats hold, hold freezes both counters, otherwise count ticks toward the dwell limit.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    dwell_d     = dwell_q;
    done_d      = 1'b0;
    advance_c   = 1'b0;
    tick_c      = (presc_q == PRESC_MAX);
    dwell_max_c = ((state_q == ST_D) || (state_q == ST_G) || (state_q == ST_J)) ? LONG_MAX : SHORT_MAX;

    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_B;
        presc_d = '0;
        dwell_d = '0;
      end
    end else if (state_q > ST_J) begin
      state_d = ST_IDLE;
      presc_d = '0;
      dwell_d = '0;
    end else if (skip) begin
      advance_c = 1'b1;
    end else if (!hold) begin
      if (tick_c) begin
        if (dwell_q == dwell_max_c) begin
          advance_c = 1'b1;
        end else begin
          dwell_d = dwell_q + DW'(1);
          presc_d = '0;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (advance_c) begin
      presc_d = '0;
      dwell_d = '0;
      if (state_q == ST_J) begin
        done_d = 1'b1;
`ifdef SEQ_LOOP_EN
        state_d = ST_B;
`else
        state_d = ST_IDLE;
`endif
      end else begin
        state_d = state_e'(state_q + 4'd1);
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign stateout = state_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: a per-cycle reference model pushes expected outputs, a monitor pops and compares.
module tb_state_sequencer;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned DWELL_SHORT = 2;
  localparam int unsigned DWELL_LONG  = 3;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       skip = 1'b0;
  logic [3:0] stateout;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  state_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .DWELL_SHORT(DWELL_SHORT),
    .DWELL_LONG (DWELL_LONG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold    (hold),
    .skip    (skip),
    .stateout(stateout),
    .busy    (busy),
    .done    (done)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [5:0] exp_q[$];

  // Reference model: state code plus the number of non-held cycles already spent in it.
  int m_state = 0;
  int m_age   = 0;
  bit m_done  = 1'b0;

  function automatic int dwell_cycles(int s);
    return ((s == 3 || s == 6 || s == 9) ? DWELL_LONG : DWELL_SHORT) * TICK_DIV;
  endfunction

  task automatic model_step(bit r, bit st, bit h, bit sk);
    bit adv;
    m_done = 1'b0;
    if (r) begin
      m_state = 0;
      m_age   = 0;
    end else if (m_state == 0) begin
      if (st) begin
        m_state = 1;
        m_age   = 0;
      end
    end else begin
      adv = sk || (!h && (m_age == dwell_cycles(m_state) - 1));
      if (adv) begin
        if (m_state == 9) begin
          m_done  = 1'b1;
          m_state = LOOP ? 1 : 0;
        end else begin
          m_state = m_state + 1;
        end
        m_age = 0;
      end else if (!h) begin
        m_age = m_age + 1;
      end
    end
  endtask

  task automatic check(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, expv);
    end
  endtask

  task automatic step(bit r, bit st, bit h, bit sk);
    @(negedge clk);
    rst   = r;
    start = st;
    hold  = h;
    skip  = sk;
    model_step(r, st, h, sk);
    exp_q.push_back({4'(m_state), (m_state != 0), m_done});
  endtask

  task automatic wait_state(int s, int a, bit st);
    for (int i = 0; i < 400; i++) begin
      if (m_state == s && m_age == a) return;
      step(1'b0, st, 1'b0, 1'b0);
    end
    checks++;
    failures++;
    $display("FAIL wait_state timeout: reached state %0d age %0d, required state %0d age %0d", m_state, m_age, s, a);
  endtask

  // Monitor: the DUT presents an output every cycle; compare just after each edge.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stateout", int'(stateout), int'(e[5:2]));
        check("busy", int'(busy), int'(e[1]));
        check("done", int'(done), int'(e[0]));
      end
    end
  end

  initial begin
    // Reset, then idle with start low.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Full sequence from a single start pulse.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (90) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Hold for 5 cycles starting at cycle 3 of c.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    wait_state(2, 2, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Skip in first cycle of e, then skip together with hold in f.
    wait_state(4, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-run in g, then start held high for back-to-back sequences.
    wait_state(6, 3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (300) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized mix of start, hold, skip and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
    end

    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
